pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, stall and flush (bubble insertion), for use between any two processor stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data payload and a separate control field. On flush the control field is forced to a safe bubble value, so a flushed slot cannot write memory or the register file. A saturating bubble counter supports pipeline performance measurement.

## Interface
- DATA_W, 32: payload width (operands, immediate, shamt, register indices, packed by the caller).
- CTRL_W, 8: control field width (mem_wr, reg_wr, sel_wb, alu_sel, ... packed).
- RST_CTRL, {CTRL_W{1'b0}}: control value loaded on reset and on flush (bubble/NOP).
- CNT_W, 16: bubble counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control field.
- flush  in  1  kill all held and incoming beats at the next edge.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  registered payload.
- out_ctrl  out  CTRL_W  registered control field.
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0.

## Operation
- Accept: in_valid && in_ready at an edge. Emit: out_valid && out_ready at an edge.
- Base mode (no skid): in_ready = !rst && (!out_valid || out_ready), combinational. On accept, out_data/out_ctrl are loaded and out_valid is set to 1. On emit without accept, out_valid is cleared to 0.
- Stall: out_ready=0 with out_valid=1 holds out_data/out_ctrl/out_valid unchanged and drives in_ready=0.
- Flush has priority over accept and emit:
  - next edge: out_valid=0, out_ctrl=RST_CTRL, out_data unchanged.
  - The beat presented with flush is dropped even if in_ready=1.
  - Any skid entry is discarded.
- Bubble: with out_valid=0, out_data holds its last loaded value and out_ctrl is RST_CTRL. Downstream decodes only out_ctrl.
- bubble_cnt: +1 at each edge where !rst && !out_valid. Saturates at 2^CNT_W-1 with no wrap. Cleared only by rst.
- Reset, synchronous at the edge with rst=1:
  - out_valid=0, out_ctrl=RST_CTRL, out_data=0, bubble_cnt=0, skid empty.
  - in_ready=0 while rst is high.
  - rst dominates flush and any in-flight beat.

## Timing
- Latency is 1 cycle from accept edge to out_valid. Throughput is 1 beat/cycle when out_ready is held high.
- A simultaneous accept and emit on a full register replaces the contents in the same edge with no bubble.
- Base mode: out_ready propagates combinationally to in_ready. This is the only comb path through the block.
- No negedge or half-cycle behaviour. All outputs except base-mode in_ready are registers on the rising edge.
- The first accept can occur on the first edge after rst deasserts.

## Configuration
- PIPE_STAGE_REG_SKID_EN defined: adds a one-entry skid buffer. in_ready is registered and equals !skid_valid.
  - If out_ready drops while a beat is accepted, that beat goes to skid.
  - Skid drains to the output first, preserving order. Max occupancy is 2.
  - No comb path from out_ready to in_ready. Latency is still 1 cycle when skid is empty.
- Not defined: base mode as above. No skid storage is synthesised.

## Structure
- Shared package pipe_pkg: default DATA_W/CTRL_W, per-stage control-field bit positions, and RST_CTRL constants for the ID/EX, EX/MEM and MEM/WB bubbles.
- Sub-module pipe_skid_buf holds the skid storage and ordering. It is instantiated only under PIPE_STAGE_REG_SKID_EN.
- The bubble counter stays inline.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1 and in_data=32'hDEADBEEF. Expected: out_valid=0, out_data=0, out_ctrl=RST_CTRL, bubble_cnt=0, in_ready=0.
- Streaming: out_ready=1, beats 1..8 on consecutive cycles. Expected: out_data sequence 1..8 one cycle later, no gaps, bubble_cnt frozen.
- Stall: accept 32'hA5, then out_ready=0 for 3 cycles with in_valid=1 and in_data=32'hB6.
  - Expected: out_data holds A5 and in_ready=0 (base mode).
  - With skid: B6 is accepted once, then in_ready=0.
  - Release: output sequence is A5 then B6.
- Flush: flush=1 while out_valid=1, out_ctrl=8'hFF, and an incoming beat 32'h77. Expected: next cycle out_valid=0, out_ctrl=RST_CTRL, 77 never appears, skid empty.
- Reset mid-stall: out_valid=1, out_ready=0, skid full, then rst=1 for one cycle. Expected: all outputs at reset values, and the first post-reset accept emerges cleanly.
- Saturation: CNT_W=4, idle for 20 cycles. Expected: bubble_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the processor pipeline stage registers:
//   - default payload / control widths
//   - per-stage control-field layouts (packed structs) and their bit positions
//   - bubble (reset/flush) control values for the ID/EX, EX/MEM and MEM/WB stages
// A bubble control word must never write memory or the register file.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_PASS = 3'd4,
        ALU_XOR  = 3'd5,
        ALU_SLL  = 3'd6,
        ALU_SRL  = 3'd7
    } alu_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } sel_wb_e;

    // ID/EX control word, LSB first: reg_wr, mem_wr, mem_rd, sel_wb[1:0], alu_sel[2:0]
    typedef struct packed {
        alu_sel_e alu_sel;
        sel_wb_e  sel_wb;
        logic     mem_rd;
        logic     mem_wr;
        logic     reg_wr;
    } idex_ctrl_t;

    localparam int IDEX_REG_WR_BIT  = 0;
    localparam int IDEX_MEM_WR_BIT  = 1;
    localparam int IDEX_MEM_RD_BIT  = 2;
    localparam int IDEX_SEL_WB_LSB  = 3;
    localparam int IDEX_ALU_SEL_LSB = 5;

    // EX/MEM control word, LSB first: reg_wr, mem_wr, mem_rd, sel_wb[1:0], spare[2:0]
    typedef struct packed {
        logic [2:0] spare;
        sel_wb_e    sel_wb;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
    } exmem_ctrl_t;

    localparam int EXMEM_REG_WR_BIT = 0;
    localparam int EXMEM_MEM_WR_BIT = 1;
    localparam int EXMEM_MEM_RD_BIT = 2;
    localparam int EXMEM_SEL_WB_LSB = 3;

    // MEM/WB control word, LSB first: reg_wr, sel_wb[1:0], spare[4:0]
    typedef struct packed {
        logic [4:0] spare;
        sel_wb_e    sel_wb;
        logic       reg_wr;
    } memwb_ctrl_t;

    localparam int MEMWB_REG_WR_BIT = 0;
    localparam int MEMWB_SEL_WB_LSB = 1;

    // Bubble words: all write/read enables low. The ID/EX bubble selects the
    // pass-through ALU op so a bubble never exercises the adder/shifter paths.
    localparam idex_ctrl_t IDEX_BUBBLE = '{
        alu_sel: ALU_PASS, sel_wb: WB_ALU, mem_rd: 1'b0, mem_wr: 1'b0, reg_wr: 1'b0
    };
    localparam exmem_ctrl_t EXMEM_BUBBLE = '{
        spare: 3'b000, sel_wb: WB_ALU, mem_rd: 1'b0, mem_wr: 1'b0, reg_wr: 1'b0
    };
    localparam memwb_ctrl_t MEMWB_BUBBLE = '{
        spare: 5'b00000, sel_wb: WB_ALU, reg_wr: 1'b0
    };

    localparam logic [CTRL_W_DEF-1:0] IDEX_RST_CTRL  = IDEX_BUBBLE;   // 8'h80
    localparam logic [CTRL_W_DEF-1:0] EXMEM_RST_CTRL = EXMEM_BUBBLE;  // 8'h00
    localparam logic [CTRL_W_DEF-1:0] MEMWB_RST_CTRL = MEMWB_BUBBLE;  // 8'h00

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// One-entry skid buffer for pipe_stage_reg. Holds a beat that was accepted
// while the output register was stalled, and decides what loads into the
// output register next (skid entry first, so order is preserved).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard the skid entry at the next edge
//   in_valid/in_data/in_ctrl   upstream beat
//   out_valid         current valid of the owning output register
//   out_ready         downstream ready
//   skid_valid        skid entry occupied (registered; upstream ready = !skid_valid)
//   load              output register loads load_data/load_ctrl this edge
//   load_data/load_ctrl        value to load into the output register
// -----------------------------------------------------------------------------
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              out_valid,
    input  logic              out_ready,
    output logic              skid_valid,
    output logic              load,
    output logic [DATA_W-1:0] load_data,
    output logic [CTRL_W-1:0] load_ctrl
);

    logic              slot_free;
    logic              accept;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // The output register can take a new value this edge when it is empty or
    // its current beat is leaving.
    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && !skid_valid && !rst;

    assign load      = slot_free && (skid_valid || accept);
    assign load_data = skid_valid ? skid_data : in_data;
    assign load_ctrl = skid_valid ? skid_ctrl : in_ctrl;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            skid_valid <= 1'b0;
        end else if (skid_valid && slot_free) begin
            skid_valid <= 1'b0;
        end else if (accept && !slot_free) begin
            skid_valid <= 1'b1;
        end
    end

    // NOTE: the skid payload is not reset; it is only ever read while
    // skid_valid is set, and skipping reset keeps the storage plain flops.
    always_ff @(posedge clk) begin
        if (accept && !slot_free) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Pipeline stage register with valid/ready handshake, stall and flush.
// Flush (and reset) forces the control field to RST_CTRL so a killed slot can
// never write memory or the register file; out_data is left as-is on flush.
// A saturating counter records cycles with no valid beat at the output.
//
// Build option: define PIPE_STAGE_REG_SKID_EN to add a one-entry skid buffer
// (registered in_ready, no combinational out_ready -> in_ready path).
// Without it, in_ready is a combinational function of out_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake
//   in_data/in_ctrl       upstream payload and control field
//   flush                 kill held and incoming beats at the next edge
//   out_valid/out_ready   downstream handshake
//   out_data/out_ctrl     registered payload and control field
//   bubble_cnt            saturating count of edges with out_valid low
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] RST_CTRL = {CTRL_W{1'b0}},
    parameter int                CNT_W    = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              load;
    logic [DATA_W-1:0] load_data;
    logic [CTRL_W-1:0] load_ctrl;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic skid_valid;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .skid_valid (skid_valid),
        .load       (load),
        .load_data  (load_data),
        .load_ctrl  (load_ctrl)
    );

    // Ready depends only on registered skid state (plus reset), so out_ready
    // never reaches in_ready combinationally.
    assign in_ready = !rst && !skid_valid;
`else
    assign in_ready  = !rst && (!out_valid || out_ready);
    assign load      = in_valid && in_ready;
    assign load_data = in_data;
    assign load_ctrl = in_ctrl;
`endif

    // Priority: reset, flush, load (accept, possibly with a simultaneous emit),
    // then emit-only, which leaves a bubble carrying RST_CTRL.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= RST_CTRL;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= RST_CTRL;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_ctrl  <= load_ctrl;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_ctrl  <= RST_CTRL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed testbench for pipe_stage_reg. A second instance with a 4-bit bubble
// counter shares all inputs and is used for the saturation scenario.
// Expected values are hand-computed; mode-dependent expectations follow
// PIPE_STAGE_REG_SKID_EN.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int              DW     = 32;
    localparam int              CW     = 8;
    localparam logic [CW-1:0]   BUBBLE = 8'h80;
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          flush;
    logic          out_ready;

    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [15:0]   bubble_cnt;

    logic          sat_in_ready;
    logic          sat_out_valid;
    logic [DW-1:0] sat_out_data;
    logic [CW-1:0] sat_out_ctrl;
    logic [3:0]    sat_bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DW), .CTRL_W (CW), .RST_CTRL (IDEX_RST_CTRL), .CNT_W (16)
    ) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
        .in_data (in_data), .in_ctrl (in_ctrl), .flush (flush),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .out_ctrl (out_ctrl), .bubble_cnt (bubble_cnt)
    );

    pipe_stage_reg #(
        .DATA_W (DW), .CTRL_W (CW), .RST_CTRL (IDEX_RST_CTRL), .CNT_W (4)
    ) dut_sat (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (sat_in_ready),
        .in_data (in_data), .in_ctrl (in_ctrl), .flush (flush),
        .out_valid (sat_out_valid), .out_ready (out_ready), .out_data (sat_out_data),
        .out_ctrl (sat_out_ctrl), .bubble_cnt (sat_bubble_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_ctrl = 8'h3C;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during: got %b want 0", in_ready); end
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (out_ctrl !== BUBBLE) begin errors++; $display("FAIL reset_out_ctrl: got %h want %h", out_ctrl, BUBBLE); end
        checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(8'h10 + i);
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_data !== DW'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, DW'(i)); end
            checks++; if (out_ctrl !== CW'(8'h10 + i)) begin errors++; $display("FAIL stream_ctrl[%0d]: got %h want %h", i, out_ctrl, CW'(8'h10 + i)); end
            checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL stream_bubble_cnt[%0d]: got %0d want 1", i, bubble_cnt); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b want 0", out_valid); end
        checks++; if (out_ctrl !== BUBBLE) begin errors++; $display("FAIL stream_drain_ctrl: got %h want %h", out_ctrl, BUBBLE); end
        checks++; if (out_data !== 32'h8) begin errors++; $display("FAIL stream_drain_data: got %h want 8", out_data); end
        checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL stream_drain_cnt: got %0d want 1", bubble_cnt); end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_data = 32'hA5; in_ctrl = 8'h0A; out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 32'hA5) begin errors++; $display("FAIL stall_first_data: got %h want a5", out_data); end
        in_data = 32'hB6; in_ctrl = 8'h0B; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== SKID) begin errors++; $display("FAIL stall_in_ready_entry: got %b want %b", in_ready, SKID); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid); end
            checks++; if (out_data !== 32'hA5) begin errors++; $display("FAIL stall_data[%0d]: got %h want a5", k, out_data); end
            checks++; if (out_ctrl !== 8'h0A) begin errors++; $display("FAIL stall_ctrl[%0d]: got %h want 0a", k, out_ctrl); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== !SKID) begin errors++; $display("FAIL stall_release_in_ready: got %b want %b", in_ready, !SKID); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'hB6) begin errors++; $display("FAIL stall_release_data: got %h want b6", out_data); end
        checks++; if (out_ctrl !== 8'h0B) begin errors++; $display("FAIL stall_release_ctrl: got %h want 0b", out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready_after: got %b want 1", in_ready); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'hFF; out_ready = 1'b1;
        tick();
        checks++; if (out_ctrl !== 8'hFF) begin errors++; $display("FAIL flush_setup_ctrl: got %h want ff", out_ctrl); end
        out_ready = 1'b0; in_data = 32'h22; in_ctrl = 8'h22;
        tick();
        checks++; if (out_data !== 32'h11) begin errors++; $display("FAIL flush_setup_hold: got %h want 11", out_data); end
        flush = 1'b1; in_data = 32'h77; in_ctrl = 8'h77;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (out_ctrl !== BUBBLE) begin errors++; $display("FAIL flush_ctrl: got %h want %h", out_ctrl, BUBBLE); end
        checks++; if (out_data !== 32'h11) begin errors++; $display("FAIL flush_data_kept: got %h want 11", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_valid[%0d]: got %b want 0", k, out_valid); end
            checks++; if (out_data !== 32'h11) begin errors++; $display("FAIL flush_after_data[%0d]: got %h want 11", k, out_data); end
        end
    endtask

    task automatic test_reset_mid_stall();
        in_valid = 1'b1; in_data = 32'h33; in_ctrl = 8'h33; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_data = 32'h44; in_ctrl = 8'h44;
        tick();
        checks++; if (out_data !== 32'h33) begin errors++; $display("FAIL rst_stall_setup: got %h want 33", out_data); end
        rst = 1'b1; in_data = 32'h99; in_ctrl = 8'h99;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_in_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_stall_data: got %h want 0", out_data); end
        checks++; if (out_ctrl !== BUBBLE) begin errors++; $display("FAIL rst_stall_ctrl: got %h want %h", out_ctrl, BUBBLE); end
        checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d want 0", bubble_cnt); end
        rst = 1'b0; in_data = 32'h55; in_ctrl = 8'h55; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_stall_ready_after: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_stall_first_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'h55) begin errors++; $display("FAIL rst_stall_first_data: got %h want 55", out_data); end
        checks++; if (out_ctrl !== 8'h55) begin errors++; $display("FAIL rst_stall_first_ctrl: got %h want 55", out_ctrl); end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_tail_valid[%0d]: got %b want 0", k, out_valid); end
            checks++; if (out_data !== 32'h55) begin errors++; $display("FAIL rst_stall_tail_data[%0d]: got %h want 55", k, out_data); end
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (sat_bubble_cnt !== 4'd0) begin errors++; $display("FAIL sat_reset_cnt: got %0d want 0", sat_bubble_cnt); end
        repeat (15) tick();
        checks++; if (sat_bubble_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt_at_15: got %0d want 15", sat_bubble_cnt); end
        checks++; if (bubble_cnt !== 16'd15) begin errors++; $display("FAIL wide_cnt_at_15: got %0d want 15", bubble_cnt); end
        repeat (5) tick();
        checks++; if (sat_bubble_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt_held: got %0d want 15", sat_bubble_cnt); end
        checks++; if (bubble_cnt !== 16'd20) begin errors++; $display("FAIL wide_cnt_at_20: got %0d want 20", bubble_cnt); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
